udp_tx_frame: RTL and testbench

UDP_TX_FRAME -- requirements
Module: udp_tx_frame

---
 rtl/udp_tx_frame.sv | 203 ++++++++++++++++++++
 tb/tb_udp_tx_frame.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_frame.sv
// UDP/IPv4 frame transmitter over GMII: preamble, MAC/IP/UDP headers, RAM payload, CRC-32 FCS.
// Defining ETH_PAD_EN adds zero padding up to the 60-byte Ethernet minimum (DST_MAC..pad).

module udp_tx_frame #(
    parameter logic [47:0] DST_MAC  = 48'h902E16BC8067,
    parameter logic [47:0] SRC_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] SRC_IP   = 32'hC0A80002,
    parameter logic [31:0] DST_IP   = 32'hC0A80003,
    parameter logic [15:0] SRC_PORT = 16'h1F90,
    parameter logic [15:0] DST_PORT = 16'h1F90,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned IFG      = 12
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              tx_trig,
    input  logic [15:0]       tx_data_length,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [31:0]       ram_rd_data,
    output logic              txen,
    output logic              txer,
    output logic [7:0]        dataout,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       ip_id
);

    typedef enum logic [3:0] {
        S_IDLE, S_CSUM, S_PRE, S_MAC, S_IPH, S_DATA, S_PAD, S_FCS, S_GAP
    } state_e;

    localparam logic [15:0] GAP_LAST  = (IFG > 0) ? 16'(IFG - 1) : 16'd0;
    localparam logic [31:0] CONST_SUM = 32'h0000_4500 + 32'h0000_4000 + 32'h0000_8011
                                      + {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]}
                                      + {16'd0, DST_IP[31:16]} + {16'd0, DST_IP[15:0]};

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         sum_q, sum_d;
    logic [31:0]         crc_q, crc_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                txen_q, txen_d;
    logic [7:0]          data_q, data_d;
    logic                done_q, done_d;
    logic [15:0]         id_q, id_d;

    logic [15:0]         pay_len, tot_len, csum;
    logic [223:0]        ip_hdr;
    logic [111:0]        mac_hdr;
    state_e              after_data;

    // Reflected CRC-32 (poly 04C11DB7), one byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ b[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    assign pay_len = len_q - 16'd8;
    assign tot_len = len_q + 16'd20;
    assign csum    = ~sum_q[15:0];
    assign ip_hdr  = {16'h4500, tot_len, id_q, 16'h4000, 16'h8011, csum, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, len_q, 16'h0000};
    assign mac_hdr = {DST_MAC, SRC_MAC, 16'h0800};

`ifdef ETH_PAD_EN
    logic [15:0] pad_len;
    assign pad_len    = (pay_len < 16'd18) ? (16'd18 - pay_len) : 16'd0;
    assign after_data = (pad_len != 16'd0) ? S_PAD : S_FCS;
`else
    assign after_data = S_FCS;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            crc_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            txen_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            crc_q   <= crc_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            txen_q  <= txen_d;
            data_q  <= data_d;
            done_q  <= done_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_trig) state_d = S_CSUM;
            end
            S_CSUM: if (cnt_q == 16'd2)  begin state_d = S_PRE; cnt_d = '0; end
            S_PRE:  if (cnt_q == 16'd7)  begin state_d = S_MAC; cnt_d = '0; end
            S_MAC:  if (cnt_q == 16'd13) begin state_d = S_IPH; cnt_d = '0; end
            S_IPH:  if (cnt_q == 16'd27) begin
                state_d = (pay_len != 16'd0) ? S_DATA : after_data;
                cnt_d   = '0;
            end
            S_DATA: if (cnt_q == pay_len - 16'd1) begin state_d = after_data; cnt_d = '0; end
`ifdef ETH_PAD_EN
            S_PAD:  if (cnt_q == pad_len - 16'd1) begin state_d = S_FCS; cnt_d = '0; end
`endif
            S_FCS:  if (cnt_q == 16'd3)  begin state_d = S_GAP; cnt_d = '0; end
            S_GAP:  if (cnt_q >= GAP_LAST) begin state_d = S_IDLE; cnt_d = '0; end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d  = len_q;
        sum_d  = sum_q;
        crc_d  = crc_q;
        word_d = word_q;
        addr_d = addr_q;
        txen_d = 1'b0;
        data_d = '0;
        done_d = 1'b0;
        id_d   = id_q;
        case (state_q)
            S_IDLE: if (tx_trig) begin
                len_d  = (tx_data_length < 16'd8) ? 16'd8 : tx_data_length;
                addr_d = '0;
                crc_d  = '1;
            end
            S_CSUM: sum_d = (cnt_q == 16'd0) ? (CONST_SUM + {16'd0, tot_len} + {16'd0, id_q})
                                             : ({16'd0, sum_q[15:0]} + {16'd0, sum_q[31:16]});
            S_PRE: begin
                txen_d = 1'b1;
                data_d = (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
            end
            S_MAC: begin
                txen_d = 1'b1;
                data_d = 8'(mac_hdr >> {4'd13 - cnt_q[3:0], 3'b000});
                crc_d  = crc_next(crc_q, data_d);
            end
            S_IPH: begin
                txen_d = 1'b1;
                data_d = 8'(ip_hdr >> {5'd27 - cnt_q[4:0], 3'b000});
                crc_d  = crc_next(crc_q, data_d);
            end
            // First byte of each word comes straight from the RAM; the word is kept for bytes 1..3
            // while the next address is already presented.
            S_DATA: begin
                txen_d = 1'b1;
                if (cnt_q[1:0] == 2'd0) begin
                    data_d = ram_rd_data[31:24];
                    word_d = ram_rd_data;
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    data_d = 8'(word_q >> {2'd3 - cnt_q[1:0], 3'b000});
                end
                crc_d = crc_next(crc_q, data_d);
            end
`ifdef ETH_PAD_EN
            S_PAD: begin
                txen_d = 1'b1;
                crc_d  = crc_next(crc_q, data_d);
            end
`endif
            S_FCS: begin
                txen_d = 1'b1;
                data_d = 8'(~crc_q >> {cnt_q[1:0], 3'b000});
            end
            S_GAP: if (cnt_q == 16'd0) begin
                done_d = 1'b1;
                id_d   = id_q + 16'd1;
            end
            default: ;
        endcase
    end

    assign ram_rd_addr = addr_q;
    assign txen        = txen_q;
    assign txer        = 1'b0;
    assign dataout     = data_q;
    assign busy        = (state_q != S_IDLE);
    assign tx_done     = done_q;
    assign ip_id       = id_q;

endmodule

// File: tb/tb_udp_tx_frame.sv
// Directed bench for udp_tx_frame: vector table of frames plus abort, trigger-ignore and address-wrap cases.
// Expected frame lengths depend on whether ETH_PAD_EN is defined.

module tb_udp_tx_frame;

    localparam int IFG = 12;

`ifdef ETH_PAD_EN
    localparam int L8 = 72, L24 = 72, L25 = 72;
`else
    localparam int L8 = 54, L24 = 70, L25 = 71;
`endif

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        tx_trig = 1'b0;
    logic [15:0] tx_data_length = '0;
    logic [7:0]  ram_rd_addr;
    logic [31:0] ram_rd_data = '0;
    logic        txen, txer, busy, tx_done;
    logic [7:0]  dataout;
    logic [15:0] ip_id;

    int checks = 0;
    int failures = 0;

    udp_tx_frame #(.ADDR_W(8), .IFG(IFG)) dut (
        .clk(clk), .clr_n(clr_n), .tx_trig(tx_trig), .tx_data_length(tx_data_length),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .txen(txen), .txer(txer), .dataout(dataout),
        .busy(busy), .tx_done(tx_done), .ip_id(ip_id)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [7:0] addr_log[$];
    int   done_cnt = 0, rise_cnt = 0, low_run = 1000, txer_bad = 0;
    logic prev_txen = 1'b0;
    logic [7:0] prev_addr = '0;

    always @(negedge clk) begin
        if (txen) begin
            if (!prev_txen) begin
                rise_cnt++;
                checks++;
                if (low_run < IFG) begin
                    failures++;
                    $display("FAIL gap: idle cycles %0d, required at least %0d", low_run, IFG);
                end
            end
            cap.push_back(dataout);
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_txen = txen;
        if (tx_done) done_cnt++;
        if (txer) txer_bad++;
        if (ram_rd_addr != prev_addr) addr_log.push_back(ram_rd_addr);
        prev_addr = ram_rd_addr;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic void push16(input logic [15:0] h);
        exp_q.push_back(h[15:8]);
        exp_q.push_back(h[7:0]);
    endfunction

    task automatic build_exp(input logic [15:0] len, input logic [15:0] csum, input logic [15:0] id);
        logic [15:0] eff;
        logic [31:0] w, c;
        int pay;
        eff = (len < 16'd8) ? 16'd8 : len;
        pay = int'(eff) - 8;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push16(16'h902E); push16(16'h16BC); push16(16'h8067);
        push16(16'h000A); push16(16'h3501); push16(16'hFEC0);
        push16(16'h0800);
        push16(16'h4500); push16(eff + 16'd20); push16(id); push16(16'h4000);
        push16(16'h8011); push16(csum);
        push16(16'hC0A8); push16(16'h0002); push16(16'hC0A8); push16(16'h0003);
        push16(16'h1F90); push16(16'h1F90); push16(eff); push16(16'h0000);
        for (int j = 0; j < pay; j++) begin
            w = mem[(j / 4) % 256];
            exp_q.push_back(8'(w >> (8 * (3 - (j % 4)))));
        end
`ifdef ETH_PAD_EN
        for (int j = pay; j < 18; j++) exp_q.push_back(8'h00);
`endif
        c = 32'hFFFFFFFF;
        for (int i = 8; i < exp_q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ exp_q[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    task automatic run_frame(input logic [15:0] len, input int exp_cyc, input logic [15:0] exp_csum,
                             input logic [15:0] exp_id, input bit poke, input string tag);
        int  d0, r0, n, bad;
        bit  got;
        n = 0;
        while (busy && n < 200) begin @(posedge clk); #1; n++; end
        cap.delete();
        d0 = done_cnt;
        r0 = rise_cnt;
        tx_data_length = len;
        tx_trig = 1'b1;
        @(posedge clk); #1;
        tx_trig = 1'b0;
        check({tag, " busy after accept"}, busy, 1);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tx_trig = poke && (cap.size() == 70);
            if (tx_done) begin got = 1'b1; break; end
        end
        tx_trig = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s done: no tx_done within 3000 cycles, expected one", tag);
        end
        check({tag, " ip_id after done"}, ip_id, exp_id + 16'd1);
        build_exp(len, exp_csum, exp_id);
        check({tag, " txen cycles"}, cap.size(), exp_cyc);
        check({tag, " txen bursts"}, rise_cnt - r0, 1);
        if (cap.size() >= 34) begin
            check({tag, " ip_id field"}, {cap[26], cap[27]}, exp_id);
            check({tag, " ip checksum"}, {cap[32], cap[33]}, exp_csum);
        end
        bad = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0 || cap.size() != exp_q.size()) begin
            failures++;
            if (bad >= 0)
                $display("FAIL %s frame: byte %0d got %0h, expected %0h", tag, bad, cap[bad], exp_q[bad]);
            else
                $display("FAIL %s frame: length got %0d, expected %0d", tag, cap.size(), exp_q.size());
        end
        @(negedge clk);
        check({tag, " tx_done width"}, tx_done, 0);
        check({tag, " tx_done count"}, done_cnt - d0, 1);
        if (poke) begin
            repeat (40) @(negedge clk);
            check({tag, " no frame from mid-frame trigger"}, rise_cnt - r0, 1);
            check({tag, " idle after mid-frame trigger"}, busy, 0);
        end
    endtask

    typedef struct {
        logic [15:0] len;
        int          cyc;
        logic [15:0] csum;
        logic [15:0] id;
        bit          poke;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, n;
        vecs[0] = '{16'd24,  L24, 16'h796B, 16'h0000, 1'b0};
        vecs[1] = '{16'd8,   L8,  16'h797A, 16'h0001, 1'b0};
        vecs[2] = '{16'd100, 146, 16'h791D, 16'h0002, 1'b1};
        vecs[3] = '{16'd3,   L8,  16'h7978, 16'h0003, 1'b0};
        vecs[4] = '{16'd26,  72,  16'h7965, 16'h0004, 1'b0};
        vecs[5] = '{16'd25,  L25, 16'h7965, 16'h0005, 1'b0};
        for (int i = 0; i < 256; i++)
            mem[i] = {8'(i), 8'(i ^ 8'hA5), 8'(i * 3), 8'(255 - i)};

        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {txen, txer, dataout, busy, tx_done, ram_rd_addr, ip_id}, 0);
        clr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].len, vecs[v].cyc, vecs[v].csum, vecs[v].id, vecs[v].poke,
                      $sformatf("vec%0d", v));

        // Abort a frame mid-payload with an asynchronous reset.
        n = 0;
        while (busy && n < 200) begin @(posedge clk); #1; n++; end
        cap.delete();
        d0 = done_cnt;
        tx_data_length = 16'd100;
        tx_trig = 1'b1;
        @(posedge clk); #1;
        tx_trig = 1'b0;
        n = 0;
        while (cap.size() <= 60 && n < 500) begin @(negedge clk); n++; end
        check("abort reached payload", cap.size() > 60, 1);
        #2;
        clr_n = 1'b0;
        #1;
        check("abort outputs", {txen, dataout, busy, tx_done, ram_rd_addr, ip_id}, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort no tx_done", done_cnt - d0, 0);

        run_frame(16'd24, L24, 16'h796B, 16'h0000, 1'b0, "post-abort");

        // 1024-byte payload on an 8-bit address bus: addresses 1..255 then wrap to 0.
        addr_log.delete();
        run_frame(16'd1032, 1078, 16'h757A, 16'h0001, 1'b0, "wrap");
        if (addr_log.size() > 0 && addr_log[0] == 8'd0) void'(addr_log.pop_front());
        n = -1;
        for (int i = 0; i < addr_log.size(); i++)
            if (n < 0 && addr_log[i] != 8'(i + 1)) n = i;
        checks++;
        if (addr_log.size() != 256 || n >= 0) begin
            failures++;
            $display("FAIL addr sequence: %0d changes, first bad index %0d, expected 256 changes 1..255,0",
                     addr_log.size(), n);
        end
        check("txer always low", txer_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
